// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
//
// Multi-cycle phase controller for the RISC-V core. A single clock and a set of
// per-phase enables replace the old divided clocks. Every instruction walks
// through fetch, register read, execute, an optional mul/div wait, an optional
// RAM/IO access and write-back. The block also counts retired instructions and
// raises a sticky flag when a mul/div unit never reports completion.
//
// State table
//   state  | code | meaning
//   IDLE   |  0   | parked; waits for run
//   FETCH  |  1   | ROM fetch and PC update (en_fetch)
//   DECODE |  2   | register read; decode flags latched (en_reg_rd)
//   EXEC   |  3   | ALU operate; mul/div start pulse if needed (en_alu)
//   MDWAIT |  4   | waiting for mul/div completion or timeout
//   MEM    |  5   | RAM/GPIO access until mem_ready (en_ram)
//   WB     |  6   | register write-back; instruction retires (en_reg_wr)
//   (7)    |  7   | illegal; recovers to IDLE on the next cycle
//
// Parameters
//   MULDIV_TIMEOUT  maximum number of MDWAIT cycles before write-back is forced
//   CNT_W           width of the retired-instruction counter
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   run            level; sequencing proceeds while high, parks in IDLE after WB when low
//   is_mul_div     decode result, sampled in DECODE
//   is_mem         decode result (load/store), sampled in DECODE
//   alu_complete   mul/div done, honoured in MDWAIT only
//   mem_ready      RAM/GPIO access done, honoured in MEM only
//   en_fetch       ROM fetch / PC update enable
//   en_reg_rd      register file read enable
//   en_alu         ALU operate enable
//   mul_div_start  one-cycle start pulse to the mul/div unit
//   en_ram         RAM/IO bus access enable
//   en_reg_wr      register file write-back enable
//   busy           high in every state except IDLE
//   timeout_err    sticky mul/div timeout flag, cleared only by rst
//   retired        retired-instruction count, wraps silently
//   state          current state code, for debug

module cpu_phase_sequencer #(
  parameter int MULDIV_TIMEOUT = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             is_mul_div,
  input  logic             is_mem,
  input  logic             alu_complete,
  input  logic             mem_ready,
  output logic             en_fetch,
  output logic             en_reg_rd,
  output logic             en_alu,
  output logic             mul_div_start,
  output logic             en_ram,
  output logic             en_reg_wr,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  // A timeout of 1 would give a zero-width counter; keep at least one bit.
  localparam int WAIT_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULDIV_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MDWAIT = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              md_q;
  logic              mem_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic [CNT_W-1:0]  retired_q;
  logic              wait_last;
  logic              timeout_hit;

  assign wait_last = (wait_cnt == WAIT_LAST);

  // alu_complete on the final allowed cycle still counts as a clean finish.
  assign timeout_hit = (state_q == S_MDWAIT) && !alu_complete && wait_last;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // mul/div never touches memory, so it wins when both flags are set
        if (md_q) begin
          state_d = S_MDWAIT;
        end else if (mem_q) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MDWAIT: state_d = (alu_complete || wait_last) ? S_WB : S_MDWAIT;
      S_MEM:    state_d = mem_ready ? S_WB : S_MEM;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      md_q      <= 1'b0;
      mem_q     <= 1'b0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_DECODE) begin
        md_q  <= is_mul_div;
        mem_q <= is_mem;
      end

      if (state_q == S_EXEC) begin
        wait_cnt <= '0;
      end else if (state_q == S_MDWAIT && !alu_complete && !wait_last) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end

      if (state_q == S_WB) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Moore outputs straight from the state register
  assign en_fetch      = (state_q == S_FETCH);
  assign en_reg_rd     = (state_q == S_DECODE);
  assign en_alu        = (state_q == S_EXEC);
  assign mul_div_start = (state_q == S_EXEC) && md_q;
  assign en_ram        = (state_q == S_MEM);
  assign en_reg_wr     = (state_q == S_WB);
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = timeout_q;
  assign retired       = retired_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Testbench for cpu_phase_sequencer. Each instruction is expanded into the
// list of phases it must pass through (from its decode flags and the cycle on
// which the bench chooses to answer), inputs are driven per phase, and the
// DUT outputs are compared against that phase list every cycle.

module tb_cpu_phase_sequencer;

  localparam int T  = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          is_mul_div;
  logic          is_mem;
  logic          alu_complete;
  logic          mem_ready;
  logic          en_fetch;
  logic          en_reg_rd;
  logic          en_alu;
  logic          mul_div_start;
  logic          en_ram;
  logic          en_reg_wr;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] retired;
  logic [2:0]    state;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_ret;
  logic          exp_to;
  logic          cur_md;

  cpu_phase_sequencer #(
    .MULDIV_TIMEOUT(T),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .is_mul_div(is_mul_div),
    .is_mem(is_mem),
    .alu_complete(alu_complete),
    .mem_ready(mem_ready),
    .en_fetch(en_fetch),
    .en_reg_rd(en_reg_rd),
    .en_alu(en_alu),
    .mul_div_start(mul_div_start),
    .en_ram(en_ram),
    .en_reg_wr(en_reg_wr),
    .busy(busy),
    .timeout_err(timeout_err),
    .retired(retired),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle in phase es: drive inputs, check outputs, advance past the edge.
  task automatic cyc(input logic [2:0] es, input logic md_in, input logic mem_in,
                     input logic alu_in, input logic rdy_in, input logic run_in);
    logic [6:0] en_exp;
    is_mul_div   = md_in;
    is_mem       = mem_in;
    alu_complete = alu_in;
    mem_ready    = rdy_in;
    run          = run_in;
    en_exp = {es == 3'd1, es == 3'd2, es == 3'd3, (es == 3'd3) && cur_md,
              es == 3'd5, es == 3'd6, es != 3'd0};
    check_val("state", 32'(state), 32'(es));
    check_val("enables", 32'({en_fetch, en_reg_rd, en_alu, mul_div_start,
                              en_ram, en_reg_wr, busy}), 32'(en_exp));
    check_val("retired", 32'(retired), 32'(exp_ret));
    check_val("timeout_err", 32'(timeout_err), 32'(exp_to));
    @(posedge clk);
    #1;
  endtask

  // Full instruction starting in FETCH. k: index of the MDWAIT cycle that
  // sees alu_complete (k >= T means never). d: MEM cycles with mem_ready low.
  task automatic instr(input logic md, input logic mem, input int k, input int d,
                       input logic run_next);
    int n;
    cur_md = md;
    cyc(3'd1, rb(), rb(), rb(), rb(), rb());
    cyc(3'd2, md, mem, rb(), rb(), rb());
    cyc(3'd3, rb(), rb(), rb(), rb(), rb());
    if (md) begin
      n = (k < T) ? k + 1 : T;
      for (int j = 0; j < n; j++) begin
        cyc(3'd4, rb(), rb(), (j == k), rb(), rb());
      end
      if (k >= T) exp_to = 1'b1;
    end else if (mem) begin
      for (int j = 0; j <= d; j++) begin
        cyc(3'd5, rb(), rb(), rb(), (j == d), rb());
      end
    end
    cyc(3'd6, rb(), rb(), rb(), rb(), run_next);
    exp_ret = exp_ret + 1'b1;
  endtask

  // n idle cycles with run low, then one with run high so FETCH follows.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(3'd0, rb(), rb(), rb(), rb(), 1'b0);
    end
    cyc(3'd0, rb(), rb(), rb(), rb(), 1'b1);
  endtask

  // Instruction aborted by rst in its n-th MDWAIT or MEM cycle.
  task automatic abort_instr(input logic md, input logic mem, input int n);
    logic [2:0] es;
    cur_md = md;
    es = md ? 3'd4 : 3'd5;
    cyc(3'd1, rb(), rb(), rb(), rb(), rb());
    cyc(3'd2, md, mem, rb(), rb(), rb());
    cyc(3'd3, rb(), rb(), rb(), rb(), rb());
    for (int j = 0; j < n; j++) begin
      if (j == n - 1) rst = 1'b1;
      cyc(es, rb(), rb(), 1'b0, 1'b0, rb());
    end
    rst     = 1'b0;
    exp_ret = '0;
    exp_to  = 1'b0;
    cur_md  = 1'b0;
  endtask

  initial begin
    logic md, mem, rn;
    int   k, d;
    rst          = 1'b1;
    run          = 1'b0;
    is_mul_div   = 1'b0;
    is_mem       = 1'b0;
    alu_complete = 1'b0;
    mem_ready    = 1'b0;
    exp_ret      = '0;
    exp_to       = 1'b0;
    cur_md       = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cyc(3'd0, rb(), rb(), rb(), rb(), rb());
    rst = 1'b0;
    idle(0);

    // back-to-back plain ALU instructions
    repeat (5) instr(1'b0, 1'b0, 0, 0, 1'b1);
    // load with three wait cycles
    instr(1'b0, 1'b1, 0, 3, 1'b1);
    // mul/div completing mid-wait and on the last allowed cycle
    instr(1'b1, 1'b0, 5, 0, 1'b1);
    instr(1'b1, 1'b0, T - 1, 0, 1'b1);
    // mul/div that never completes; mem flag must be ignored
    instr(1'b1, 1'b1, T + 5, 0, 1'b1);
    // run drops: load still finishes, then the block parks
    instr(1'b0, 1'b1, 0, 1, 1'b0);
    idle(3);

    for (int i = 0; i < 70; i++) begin
      md  = rb();
      mem = rb();
      k   = int'($urandom_range(0, T + 1));
      d   = int'($urandom_range(0, 4));
      rn  = ($urandom_range(0, 3) != 0);
      instr(md, mem, k, d, rn);
      if (!rn) idle(int'($urandom_range(0, 2)));
    end

    abort_instr(1'b1, 1'b0, 3);
    idle(1);
    instr(1'b1, 1'b0, T + 1, 0, 1'b1);
    abort_instr(1'b0, 1'b1, 2);
    idle(0);
    instr(1'b0, 1'b0, 0, 0, 1'b0);
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Multi-cycle phase controller for the RISC-V core. It replaces free-running divided clocks with single-clock enables. Each instruction steps through fetch, register read, execute, optional mul/div wait, optional RAM/IO access and write-back. The block sits between the core datapath and the ROM, RAM/GPIO bus, register file and mul/div unit. It also counts retired instructions and flags mul/div units that never complete.

## Interface

Parameters:
- MULDIV_TIMEOUT, default 64: maximum number of cycles spent in MDWAIT before forcing write-back.
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; the single clock for the block.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; when high, sequencing proceeds; when low, the current instruction finishes and the block parks in IDLE.
- is_mul_div  in  1  decode result; sampled only in DECODE.
- is_mem  in  1  decode result (load/store); sampled only in DECODE.
- alu_complete  in  1  mul/div done; honoured only in MDWAIT.
- mem_ready  in  1  RAM/GPIO access done; honoured only in MEM.
- en_fetch  out  1  ROM fetch and PC update enable.
- en_reg_rd  out  1  register file read / operand latch enable.
- en_alu  out  1  ALU operate enable.
- mul_div_start  out  1  one-cycle start pulse to the mul/div unit.
- en_ram  out  1  RAM/IO bus access enable.
- en_reg_wr  out  1  register file write-back enable.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky mul/div timeout flag.
- retired  out  CNT_W  retired-instruction count.
- state  out  3  current state encoding, for debug.

## Operation

- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MDWAIT=4, MEM=5, WB=6. Codes 7 and above are illegal and go to IDLE on the next cycle.
- All enables are Moore outputs decoded from the state register. Each enable is high exactly while the block is in its state:
  - en_fetch: FETCH.
  - en_reg_rd: DECODE.
  - en_alu: EXEC.
  - en_ram: every MEM cycle.
  - en_reg_wr: WB.
- mul_div_start is high in EXEC only when the latched mul_div flag is 1.
- Transitions:
  - IDLE: go to FETCH if run; otherwise stay.
  - FETCH: go to DECODE.
  - DECODE: latch is_mul_div and is_mem into md_q and mem_q; go to EXEC.
  - EXEC: go to MDWAIT if md_q; else MEM if mem_q; else WB. md_q takes priority when both flags are set; mul/div never accesses memory.
  - MDWAIT: go to WB if alu_complete. Otherwise, if wait_cnt == MULDIV_TIMEOUT-1, set timeout_err and go to WB. Otherwise increment wait_cnt and stay.
  - MEM: go to WB if mem_ready; otherwise stay, holding en_ram high.
  - WB: increment retired; go to FETCH if run, else IDLE.
- wait_cnt:
  - width is clog2(MULDIV_TIMEOUT);
  - cleared in EXEC;
  - counts MDWAIT cycles.
- If alu_complete arrives in the same cycle the timeout is reached, alu_complete wins and timeout_err is not set.
- alu_complete outside MDWAIT and mem_ready outside MEM are ignored.
- run dropping mid-instruction has no effect until WB.
- retired wraps modulo 2^CNT_W with no flag.
- timeout_err stays set until rst.

## Timing

- Reset: on a clk edge with rst=1:
  - state is IDLE;
  - all enables, mul_div_start, busy and timeout_err are 0;
  - retired, wait_cnt, md_q and mem_q are 0.
- Reset mid-instruction aborts the instruction with no WB and no retired increment. It takes effect at that edge regardless of state.
- rst is synchronous: any outputs asserted in the cycle where rst is sampled high remain asserted until that edge.
- Latency, counted from the first FETCH cycle:
  - plain ALU instruction: 4 cycles;
  - load/store with mem_ready already high in the first MEM cycle: 5 cycles;
  - each cycle mem_ready stays low adds 1 cycle;
  - mul/div with alu_complete in the first MDWAIT cycle: 5 cycles;
  - mul/div maximum: 4 + MULDIV_TIMEOUT cycles.
- Throughput with run held high: back-to-back instructions with no idle cycle. FETCH follows WB directly.
- run rising in IDLE produces FETCH on the next cycle.

## Test plan

- Reset then run=1, is_mul_div=0, is_mem=0 → state sequence 1,2,3,6 repeating. en_reg_wr pulses every 4 cycles and retired reaches 5 after 20 cycles.
- Load with is_mem=1 and mem_ready held low for 3 MEM cycles then high → en_ram high 4 consecutive cycles, WB on the next cycle, 8 cycles total.
- Mul/div with alu_complete asserted in the 10th MDWAIT cycle → mul_div_start exactly one cycle (in EXEC), WB follows, timeout_err=0.
- Mul/div with MULDIV_TIMEOUT=8 and alu_complete never asserted → exactly 8 MDWAIT cycles, then WB. timeout_err=1 and stays 1 through later instructions until rst.
- Drop run during EXEC → MEM/WB still complete, state goes to IDLE, busy=0. Reassert run → FETCH on the next cycle.
- rst asserted during MDWAIT and during MEM → all outputs 0 next cycle; retired is not incremented for the aborted instruction.
